// File: rtl/spike_event_logger.sv
// Timestamps rising edges of the neuron spike and queues {ts, state} events in a FWFT FIFO.
// Optional windowed spike-rate counter is compiled in with `define SPIKE_LOG_RATE_EN.
module spike_event_logger #(
  parameter int TS_W     = 16,
  parameter int DEPTH    = 4,
  parameter int WIN_LOG2 = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     spike,
  input  logic [7:0]               state,
  input  logic                     ev_ready,
  output logic                     ev_valid,
  output logic [TS_W-1:0]          ev_ts,
  output logic [7:0]               ev_state,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [WIN_LOG2:0]        rate
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [TS_W-1:0]   r_ts_cnt;
  logic              r_spike_d;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_ovf;
  logic [TS_W+7:0]   r_mem [DEPTH];

  logic              w_event;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [TS_W+7:0]   w_head;

  assign w_event = ena & spike & ~r_spike_d;
  assign w_full  = (r_level == FULL_LVL);
  assign w_pop   = (r_level != '0) & ev_ready;
  // A full FIFO still accepts the event when the head leaves on the same edge.
  assign w_push  = w_event & (~w_full | w_pop);
  assign w_drop  = w_event & w_full & ~w_pop;

  assign w_head   = r_mem[r_rd_ptr];
  assign ev_valid = (r_level != '0);
  assign ev_ts    = w_head[TS_W+7:8];
  assign ev_state = w_head[7:0];
  assign level    = r_level;
  assign ovf      = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts_cnt  <= '0;
      r_spike_d <= 1'b0;
    end else if (ena) begin
      r_ts_cnt  <= r_ts_cnt + TS_W'(1);
      r_spike_d <= spike;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_ts_cnt, state};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Set has priority over clear so a drop in the clear cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef SPIKE_LOG_RATE_EN
  logic [WIN_LOG2-1:0] r_win;
  logic [WIN_LOG2:0]   r_acc;
  logic [WIN_LOG2:0]   r_rate;
  logic                w_wrap;

  assign w_wrap = ena & (r_win == '1);
  assign rate   = r_rate;

  // Dropped events are still counted: the accumulator sees every detected edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win  <= '0;
      r_acc  <= '0;
      r_rate <= '0;
    end else if (ena) begin
      r_win <= r_win + WIN_LOG2'(1);
      if (w_wrap) begin
        r_rate <= r_acc + {{WIN_LOG2{1'b0}}, w_event};
        r_acc  <= '0;
      end else if (w_event) begin
        r_acc  <= r_acc + (WIN_LOG2+1)'(1);
      end
    end
  end
`else
  assign rate = '0;
`endif

endmodule

// File: tb/tb_spike_event_logger.sv
// Self-checking bench for spike_event_logger: directed scenarios plus random traffic
// compared each cycle against a queue-based event model.
module tb_spike_event_logger;
  localparam int TS_W     = 8;
  localparam int DEPTH    = 4;
  localparam int WIN_LOG2 = 4;
  localparam int WIN      = 1 << WIN_LOG2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b0;
  logic              spike = 1'b0;
  logic [7:0]        state = 8'h00;
  logic              ev_ready = 1'b0;
  logic              ovf_clr = 1'b0;
  logic              ev_valid;
  logic [TS_W-1:0]   ev_ts;
  logic [7:0]        ev_state;
  logic [2:0]        level;
  logic              ovf;
  logic [WIN_LOG2:0] rate;

  spike_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .WIN_LOG2(WIN_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike(spike), .state(state),
    .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_ts(ev_ts), .ev_state(ev_state),
    .level(level), .ovf(ovf), .ovf_clr(ovf_clr), .rate(rate)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ts;
    int st;
  } ev_t;

  int  errors = 0;
  int  checks = 0;
  ev_t q[$];
  int  m_ts, m_win, m_acc, m_rate;
  bit  m_prev, m_ovf;
  bit  verbose = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts = 0; m_prev = 0; m_ovf = 0;
    m_win = 0; m_acc = 0; m_rate = 0;
  endtask

  task automatic compare_all();
    chk("ev_valid", ev_valid, q.size() != 0);
    chk("level", level, q.size());
    chk("ovf", ovf, m_ovf);
    if (q.size() != 0) begin
      chk("ev_ts", ev_ts, q[0].ts);
      chk("ev_state", ev_state, q[0].st);
    end
`ifdef SPIKE_LOG_RATE_EN
    chk("rate", rate, m_rate);
`else
    chk("rate", rate, 0);
`endif
  endtask

  // One clock: model decides from the inputs in force, then the edge, then compare.
  task automatic step();
    bit ev, full, pop, drop;
    ev   = ena && spike && !m_prev;
    full = (q.size() == DEPTH);
    pop  = (q.size() != 0) && ev_ready;
    @(posedge clk);
    #1;
    if (pop) begin
      if (verbose) $display("pop  ts=%0d state=0x%02h", q[0].ts, q[0].st);
      void'(q.pop_front());
    end
    drop = ev && full && !pop;
    if (ev && !drop) begin
      q.push_back('{m_ts, int'(state)});
      if (verbose) $display("push ts=%0d state=0x%02h", m_ts, state);
    end
    if (drop) begin
      m_ovf = 1;
      if (verbose) $display("drop ts=%0d", m_ts);
    end else if (ovf_clr) begin
      m_ovf = 0;
    end
    if (ena) begin
      m_ts   = (m_ts + 1) % (1 << TS_W);
      m_prev = spike;
      m_win++;
      m_acc += int'(ev);
      if (m_win == WIN) begin
        m_rate = m_acc;
        m_acc  = 0;
        m_win  = 0;
      end
    end
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called #1 after a rising edge, so the reset lands between edges.
  task automatic do_reset();
    ena = 0; spike = 0; ev_ready = 0; ovf_clr = 0;
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1;
    compare_all();
  endtask

  initial begin
    int k;
    #2;
    model_reset();
    compare_all();
    chk("reset_level", level, 0);
    chk("reset_valid", ev_valid, 0);
    chk("reset_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // Single spike held 3 cycles starting at ts=5
    ena = 1; spike = 0; ev_ready = 0;
    steps(5);
    spike = 1; state = 8'hE8;
    step();
    chk("single_valid", ev_valid, 1);
    chk("single_ts", ev_ts, 5);
    chk("single_state", ev_state, 8'hE8);
    chk("single_level", level, 1);
    state = 8'h11;
    steps(2);
    chk("single_one_event", level, 1);
    spike = 0; ev_ready = 1;
    step();
    chk("single_drained", level, 0);

    // Backpressure and overflow: events at ts 0,2,4,6,8
    do_reset();
    ena = 1; ev_ready = 0;
    for (int i = 0; i < 5; i++) begin
      spike = 1; state = 8'(8'h40 + i);
      step();
      spike = 0;
      step();
    end
    chk("ovf_level", level, 4);
    chk("ovf_set", ovf, 1);
    chk("ovf_head_ts", ev_ts, 0);
    ovf_clr = 1;
    step();
    ovf_clr = 0;
    chk("ovf_cleared", ovf, 0);

    // Full with simultaneous pop: new event at ts=11 enters the tail
    spike = 1; ev_ready = 1; state = 8'hC3;
    step();
    chk("fullpop_level", level, 4);
    chk("fullpop_ovf", ovf, 0);
    chk("fullpop_head", ev_ts, 2);
    spike = 0;
    steps(3);
    chk("fullpop_tail_ts", ev_ts, 11);
    chk("fullpop_tail_state", ev_state, 8'hC3);
    step();
    ev_ready = 0;

    // Timestamp wrap: events at 255 then 1
    do_reset();
    ena = 1; spike = 0;
    steps(255);
    spike = 1; state = 8'hA5;
    step();
    spike = 0;
    step();
    spike = 1; state = 8'h5A;
    step();
    spike = 0;
    chk("wrap_level", level, 2);
    chk("wrap_ts0", ev_ts, 255);
    chk("wrap_ovf", ovf, 0);
    ev_ready = 1;
    step();
    chk("wrap_ts1", ev_ts, 1);
    step();
    ev_ready = 0;

    // Reset mid-stream with three queued events
    do_reset();
    ena = 1;
    for (int i = 0; i < 3; i++) begin
      spike = 1; state = 8'(i);
      step();
      spike = 0;
      step();
    end
    chk("mid_level_before", level, 3);
    rst_n = 0;
    #1;
    chk("mid_valid", ev_valid, 0);
    chk("mid_level", level, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    spike = 1; state = 8'h77;
    step();
    spike = 0;
    chk("mid_ts_restart", ev_ts, 0);
    chk("mid_level_after", level, 1);

    // Rate: ena toggling, one spike edge every 4 enabled cycles
    do_reset();
    ev_ready = 1;
    k = 0;
    for (int i = 0; i < 64; i++) begin
      ena   = (i % 2 == 0);
      spike = ena && (k % 4 == 0);
      step();
      if (ena) k++;
      if (i == 31) begin
`ifdef SPIKE_LOG_RATE_EN
        chk("rate_win1", rate, 4);
`else
        chk("rate_win1", rate, 0);
`endif
      end
    end
`ifdef SPIKE_LOG_RATE_EN
    chk("rate_win2", rate, 4);
`else
    chk("rate_win2", rate, 0);
`endif

    // Random traffic
    do_reset();
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ena      = ($urandom_range(0, 3) != 0);
      spike    = $urandom_range(0, 1);
      ev_ready = ($urandom_range(0, 2) == 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      state    = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spike_event_logger.md
# spike_event_logger

Downstream consumer of the integrate-and-fire neuron stage: it watches the neuron's `spike` and `state` outputs and turns each new spike into a timestamped event. Events go into a small FIFO and drain over a valid/ready interface to the readout/IO logic. A sticky overflow flag records lost events, and an optional windowed spike-rate counter can be compiled in.

## Interface
Parameters:
- `TS_W`, 16: timestamp counter width (8..16).
- `DEPTH`, 4: FIFO depth in entries; power of two, 2..8.
- `WIN_LOG2`, 8: rate window length is 2^WIN_LOG2 enabled cycles (used only with `SPIKE_LOG_RATE_EN`).

Ports:
- `clk`, input, 1: sole clock; all flops on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `ena`, input, 1: logger enable; when low, the timestamp counter, edge detector and rate window all hold.
- `spike`, input, 1: spike level from the neuron.
- `state`, input, 8: membrane potential from the neuron.
- `ev_ready`, input, 1: consumer ready.
- `ev_valid`, output, 1: FIFO head is valid.
- `ev_ts`, output, TS_W: timestamp of the head event.
- `ev_state`, output, 8: membrane value captured with the head event.
- `level`, output, $clog2(DEPTH)+1: current FIFO occupancy.
- `ovf`, output, 1: sticky overflow flag.
- `ovf_clr`, input, 1: synchronous clear of `ovf`.
- `rate`, output, WIN_LOG2+1: spike count of the last completed window (only with the macro).

## Operation
- Timestamp: `ts_cnt` (TS_W bits) increments by 1 on every `ena` cycle and wraps from 2^TS_W-1 to 0 with no flag.
- Edge detect: `spike_d` registers `spike` on `ena` cycles.
  - An event occurs on an edge where `ena`=1, `spike`=1 and `spike_d`=0.
  - A multi-cycle high `spike` yields exactly one event.
- Push payload: {`ts_cnt` value before that edge's increment, `state` sampled at that edge}.
- FIFO:
  - DEPTH entries, read/write pointers with wrap, first-word fall-through.
  - `ev_valid` = (`level`≠0).
  - `ev_ts` and `ev_state` present the head entry combinationally from storage. When `ev_valid`=0 they are don't-care but stable.
- Pop: occurs when `ev_valid` and `ev_ready` are both high at a clock edge.
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted and `level` stays at DEPTH.
  - Otherwise the event is dropped, `ovf` is set and the FIFO is unchanged.
- Push and pop on a non-empty, non-full FIFO: `level` is unchanged.
- Push into an empty FIFO: a pop cannot occur in the same cycle because `ev_valid`=0.
- `ovf`:
  - Set by a dropped event.
  - Cleared by `ovf_clr`.
  - If set and clear happen in the same cycle, set wins.
- `ena`=0: pushes are suppressed; pops still proceed.

## Timing
- Reset values (async): `ts_cnt`=0, `spike_d`=0, pointers=0, `level`=0, `ev_valid`=0, `ovf`=0, `rate`=0, window counter=0.
- Latency: an event sampled at edge N gives `ev_valid`=1 after edge N if the FIFO was empty, so the consumer can pop at edge N+1.
- Throughput: one push and one pop per cycle.
- Reset asserted mid-operation discards all queued events immediately. The first event after release needs `spike`=1 at an enabled edge, because `spike_d` resets to 0.
- `ev_valid` never depends combinationally on `ev_ready`.

## Configuration
- Macro `SPIKE_LOG_RATE_EN`, when defined:
  - Adds a window counter of WIN_LOG2 bits plus a spike accumulator of WIN_LOG2+1 bits.
  - The accumulator counts events, including dropped ones, over 2^WIN_LOG2 enabled cycles.
  - On the wrap edge, `rate` is loaded with the accumulator value plus any event sampled on that same edge. The accumulator then restarts at 0.
  - `rate` holds its value until the next wrap.
- Macro undefined: the `rate` port still exists, is tied to 0, and no window logic is built.

## Test plan
- Single spike: release reset, `ena`=1, `spike` high for 3 cycles starting at `ts_cnt`=5, `state`=0xE8 on the first edge. Expect exactly one event {ts=5, state=0xE8}, `ev_valid` high one edge later, `level`=1.
- Backpressure/overflow:
  - `ev_ready`=0, DEPTH=4, 5 spike edges. Expect `level`=4, `ovf`=1, and the FIFO holding the first 4 timestamps.
  - Pulse `ovf_clr`: expect `ovf`=0.
- Full with simultaneous pop: FIFO full, spike edge in the same cycle as `ev_ready`=1. Expect `level` to stay at 4, `ovf`=0, and the new event in the tail.
- Wrap: TS_W=8, spike at `ts_cnt`=255 then at `ts_cnt`=1. Expect `ev_ts`=255 then 1, and no flag.
- Reset mid-stream: 3 queued events, assert `rst_n`=0 asynchronously between edges. Expect `ev_valid`=0, `level`=0 and `ts_cnt`=0 immediately.
- Rate (macro defined, WIN_LOG2=4): one spike edge every 4 enabled cycles, `ena` toggling 50%. Expect `rate`=4 after each window of 16 enabled cycles. With the macro undefined, expect `rate`=0 throughout.
